// File: rtl/updown_counter_mod.sv
// Synchronous up/down counter with a programmable modulo, clear and load, wrap or saturate mode,
// a terminal-count pulse and a sticky overflow flag. Define UDC_GRAY_OUT_EN to add the gray_count output.
module updown_counter_mod #(
  parameter int unsigned      WIDTH   = 3,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
`ifdef UDC_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] gray_count
`endif
);

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == '0);

  // Priority: clr > load > en > hold. The boundary compare uses MAX_VAL, so a
  // modulus that is not a power of two wraps correctly.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    count_nxt = count;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (load) begin
      count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          count_nxt = sat_mode ? MAX_VAL : '0;
          tc_nxt    = 1'b1;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          count_nxt = sat_mode ? '0 : MAX_VAL;
          tc_nxt    = 1'b1;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      count <= RST_VAL;
      tc    <= 1'b0;
      ovf   <= 1'b0;
`ifdef UDC_GRAY_OUT_EN
      gray_count <= RST_VAL ^ (RST_VAL >> 1);
`endif
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
`ifdef UDC_GRAY_OUT_EN
      gray_count <= count_nxt ^ (count_nxt >> 1);
`endif
    end
  end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Synchronous, parametrised up/down counter.
- Successor to the 3-bit JK-flip-flop ripple up/down counter. All state bits share one clock edge, so the output has no ripple glitches.
- Adds programmable modulo, synchronous clear and load, count enable, wrap or saturate mode, and terminal-count / underflow-overflow flags.
- Used as a generic event, address and timeout counter in the sequential-circuit library.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..32.
- MAX_VAL, (1<<WIDTH)-1, highest count value (modulus = MAX_VAL+1). Must satisfy 1 <= MAX_VAL <= 2^WIDTH-1.
- RST_VAL, 0, count value on asynchronous reset. Must be <= MAX_VAL.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- clr  input  1  synchronous clear: count <= 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  boundary mode: 1 = saturate at boundary, 0 = wrap.
- count  output  WIDTH  registered count value.
- tc  output  1  registered terminal-count pulse.
- ovf  output  1  sticky overflow/underflow flag.
- at_max  output  1  combinational: count == MAX_VAL.
- at_min  output  1  combinational: count == 0.

Behaviour:
- Reset (rst=1, asynchronous, regardless of clk):
  - count = RST_VAL, tc = 0, ovf = 0.
  - at_max and at_min follow count combinationally.
- Reset released mid-operation: the first rising edge after rst falls applies the normal priority rules below. No extra dead cycle.
- Per-edge priority: clr > load > en > hold.
- clr=1:
  - count <= 0, tc <= 0, ovf <= 0.
  - load and en are ignored that cycle.
- load=1 (clr=0):
  - count <= min(load_val, MAX_VAL); any out-of-range value is clamped.
  - tc <= 0; ovf unchanged.
- en=1, up_dn=1:
  - count < MAX_VAL: count <= count+1, tc <= 0.
  - count == MAX_VAL, sat_mode=0: count <= 0, tc <= 1, ovf <= 1.
  - count == MAX_VAL, sat_mode=1: count holds MAX_VAL, tc <= 1, ovf <= 1.
- en=1, up_dn=0:
  - count > 0: count <= count-1, tc <= 0.
  - count == 0, sat_mode=0: count <= MAX_VAL, tc <= 1, ovf <= 1.
  - count == 0, sat_mode=1: count holds 0, tc <= 1, ovf <= 1.
- en=0 (no clr/load): count holds, tc <= 0, ovf holds.
- tc timing:
  - High for exactly the one cycle after the boundary-crossing edge, i.e. alongside the new count value.
  - Held in saturation with en=1: tc re-asserts every enabled cycle.
- ovf is sticky: cleared only by rst or clr.
- Direction or mode changes take effect on the same edge they are sampled; no pipeline.
- Latency: input to count/tc/ovf is 1 clock. at_max/at_min have zero added latency from count.
- Arithmetic:
  - The modulo compare uses MAX_VAL, never 2^WIDTH. With MAX_VAL = 2^WIDTH-1 the wrap coincides with the natural binary rollover.
  - No intermediate value wider than WIDTH+1 bits.

Optional Feature:
- Macro: UDC_GRAY_OUT_EN.
- Defined:
  - Extra output port gray_count (WIDTH) = count ^ (count >> 1).
  - Registered in the same always block as count, so it has identical timing and is reset to the Gray code of RST_VAL.
  - Consecutive values differ in one bit, except across a wrap when MAX_VAL != 2^WIDTH-1.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=3, MAX_VAL=5, RST_VAL=0 unless stated):
- Reset/count up: rst=1 for 2 cycles, then en=1, up_dn=1, sat_mode=0 for 8 edges -> count 1,2,3,4,5,0,1,2; tc=1 only with count=0 after the 5->0 edge; ovf=1 from then on.
- Count down and switch direction: load load_val=2, then en=1, up_dn=0 for 4 edges -> 1,0,5,4; tc=1 with the 5. Set up_dn=1 next edge -> 5.
- Saturate: sat_mode=1, load 4, en=1, up_dn=1 for 3 edges -> 5,5,5 with tc=1 on the 2nd and 3rd edges and at_max=1. Repeat at 0 counting down -> holds 0, at_min=1.
- Priority and clamp:
  - load_val=7 -> count=5 (clamped).
  - clr=1 and load=1 with load_val=3 on the same edge -> count=0, ovf=0.
  - load=1 with en=1 -> loaded value wins.
- Async reset mid-count: assert rst between edges at count=3 -> count=0 immediately (before the next edge), tc=0, ovf=0. Repeat with RST_VAL=4 -> count=4.
- UDC_GRAY_OUT_EN with WIDTH=3, MAX_VAL=7, count up 8 edges -> gray_count 001,011,010,110,111,101,100,000, each aligned with its count value.
